// File: rtl/control_sd_itf_if.sv
// Signal bundle between the display scan sequencer, the clock/setting logic
// and the serial seven-segment datapath.
interface control_sd_itf_if;
    logic       en;
    logic [5:0] blink_en;
    logic [5:0] dp_en;
    logic [5:0] sel;
    logic [5:0] sel_sd;
    logic       dp;
    logic       tw;
    logic       upgrade;
    logic       move;
    logic       keep;
    logic       shcp;
    logic       stcp;

    modport master (
        input  en, blink_en, dp_en,
        output sel, sel_sd, dp, tw, upgrade, move, keep, shcp, stcp
    );

    modport slave (
        output en, blink_en, dp_en,
        input  sel, sel_sd, dp, tw, upgrade, move, keep, shcp, stcp
    );
endinterface

// File: rtl/control_sd_itf.sv
// Scan sequencer for the serial seven-segment display: walks six digits one-hot,
// drives load/shift/hold controls and generates shcp/stcp for the external chain.
module control_sd_itf #(
    parameter int DIV       = 2,
    parameter int HOLD      = 4,
    parameter int TW_PERIOD = 25_000_000
) (
    input logic              sysclk,
    input logic              rst,
    control_sd_itf_if.master bus
);
    localparam int CNT_MAX = (2 * DIV > HOLD) ? 2 * DIV : HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TW_W    = (TW_PERIOD > 1) ? $clog2(TW_PERIOD) : 1;

    localparam logic [CNT_W-1:0] C_SHCP       = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] C_BIT_LAST   = CNT_W'(2 * DIV - 1);
    localparam logic [CNT_W-1:0] C_LATCH_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] C_HOLD_LAST  = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);
    localparam logic [TW_W-1:0]  TW_LAST      = TW_W'(TW_PERIOD - 1);
    localparam logic [TW_W-1:0]  TW_ONE       = TW_W'(1);
    localparam logic [3:0]       BIT_LAST     = 4'd13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [5:0]       sel_q, sel_d, sel_nxt;
    logic             dp_q, dp_d;
    logic             tw_q, tw_d;
    logic [TW_W-1:0]  tw_cnt_q, tw_cnt_d;
    logic             phase_q, phase_d;
    logic             tw_wrap;
    logic             load;
    logic             upgrade, move, keep, shcp, stcp;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sel_q    <= 6'b100000;
            dp_q     <= 1'b0;
            tw_q     <= 1'b0;
            tw_cnt_q <= '0;
            phase_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sel_q    <= sel_d;
            dp_q     <= dp_d;
            tw_q     <= tw_d;
            tw_cnt_q <= tw_cnt_d;
            phase_q  <= phase_d;
        end
    end

    // Moore outputs; load flags the edge that enters LOAD.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        load    = 1'b0;
        upgrade = 1'b0;
        move    = 1'b0;
        keep    = 1'b0;
        shcp    = 1'b0;
        stcp    = 1'b0;
        case (state_q)
            S_IDLE: begin
                keep    = 1'b1;
                state_d = S_LOAD;
                load    = 1'b1;
            end
            S_LOAD: begin
                upgrade = 1'b1;
                state_d = S_SHIFT;
                cnt_d   = '0;
                bit_d   = '0;
            end
            S_SHIFT: begin
                shcp = (cnt_q >= C_SHCP);
                if (cnt_q == C_BIT_LAST) begin
                    move  = 1'b1;
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) state_d = S_LATCH;
                    else                   bit_d   = bit_q + 4'd1;
                end else begin
                    keep  = 1'b1;
                    cnt_d = cnt_q + C_ONE;
                end
            end
            S_LATCH: begin
                stcp = 1'b1;
                keep = 1'b1;
                if (cnt_q == C_LATCH_LAST) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            S_HOLD: begin
                keep = 1'b1;
                // Counter parks on its last value so en is re-checked every cycle.
                if (cnt_q == C_HOLD_LAST) begin
                    if (bus.en) begin
                        state_d = S_LOAD;
                        load    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            default: begin
                keep    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // The first LOAD after reset keeps digit 6; later ones rotate right with wrap.
    always_comb begin
        sel_nxt  = (state_q == S_HOLD) ? {sel_q[0], sel_q[5:1]} : sel_q;
        sel_d    = load ? sel_nxt : sel_q;
        dp_d     = load ? |(bus.dp_en & sel_nxt) : dp_q;
        tw_d     = load ? (|(bus.blink_en & sel_nxt)) & phase_q : tw_q;
        tw_wrap  = (tw_cnt_q == TW_LAST);
        tw_cnt_d = tw_wrap ? '0 : tw_cnt_q + TW_ONE;
        phase_d  = phase_q ^ tw_wrap;
    end

    assign bus.sel     = sel_q;
    assign bus.sel_sd  = sel_q;
    assign bus.dp      = dp_q;
    assign bus.tw      = tw_q;
    assign bus.upgrade = upgrade;
    assign bus.move    = move;
    assign bus.keep    = keep;
    assign bus.shcp    = shcp;
    assign bus.stcp    = stcp;
endmodule

// File: doc/control_sd_itf.md
# control_sd_itf

Sequencing controller for the serial seven-segment display datapath. It scans the six digits one-hot. For each digit it drives the datapath's load/shift/hold controls (`upgrade`/`move`/`keep`) and the digit-select, decimal-point and blanking fields. It also generates the shift clock `shcp` and latch strobe `stcp` for the external shift-register chain, which samples the datapath's serial output `ds`. It sits between the clock/setting logic, which supplies the per-digit blink and decimal-point masks, and the display datapath.

## Interface
- `DIV`, 2: half-period of `shcp` in `sysclk` cycles; legal range ≥1.
- `HOLD`, 4: length of the post-latch hold (display dwell) per digit, in `sysclk` cycles; legal range ≥1.
- `TW_PERIOD`, 25_000_000: `sysclk` cycles per blink half-period; legal range ≥1.
- `sysclk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: scan enable; sampled only at the end of HOLD.
- `blink_en` input 6: per-digit blink request; bit5 is digit 6, bit0 is digit 1.
- `dp_en` input 6: per-digit decimal-point request, same bit order.
- `sel` output 6: one-hot digit index into the datapath mux (100000 = digit 6).
- `sel_sd` output 6: digit-select field shifted to the board; active-high; equals `sel`.
- `dp` output 1: decimal point for the current digit; active-high, and the datapath inverts it.
- `tw` output 1: blanks the current digit's segments.
- `upgrade`, `move`, `keep` output 1 each: datapath shift-register controls. After reset, exactly one of the three is high in every cycle.
- `shcp` output 1: shift clock to the external chain.
- `stcp` output 1: latch strobe to the external chain.

## Operation
- States: IDLE → LOAD → SHIFT → LATCH → HOLD → LOAD …
- **IDLE:** entered only from reset; lasts 1 cycle.
- **LOAD:** lasts 1 cycle; `upgrade`=1.
- **SHIFT:** 14 bits, each 2·DIV cycles, tracked by a bit counter (0..13) and a phase counter c (0..2·DIV−1).
  - `shcp`=1 when c ≥ DIV, else 0.
  - `move`=1 when c = 2·DIV−1; `keep`=1 otherwise.
  - `shcp` therefore rises mid-bit while `ds` is stable.
  - `move` coincides with the last `shcp`-high cycle, so the next bit appears as `shcp` falls.
  - 14 moves per frame rotate the datapath register back to its loaded value.
- **LATCH:** DIV cycles; `stcp`=1, `keep`=1.
- **HOLD:** HOLD cycles; `keep`=1. At the last HOLD cycle:
  - if `en`=1: go to LOAD and advance `sel` one position right, wrapping 000001 → 100000;
  - if `en`=0: stay in HOLD with `keep`=1, re-checking `en` every cycle; `sel` does not advance.
- **Registered outputs:** `dp`, `tw` and `sel` update only on the transitions into LOAD (IDLE→LOAD and HOLD→LOAD), so they are stable from LOAD through HOLD.
  - `dp` = `dp_en`[index of next `sel`].
  - `tw` = `blink_en`[index of next `sel`] & `phase`.
- **Blink timer:** free-running counter 0..TW_PERIOD−1; `phase` toggles when it wraps, and it runs regardless of `en` or state.
- **`sel_sd`** is a wire copy of `sel`.
- **`en`** has no effect outside HOLD; a frame in progress always completes.

## Timing
- **Reset values** (while `rst`=1 and in the cycle after):
  - state IDLE, `sel`=`sel_sd`=100000, `dp`=0, `tw`=0, `phase`=0, blink counter 0;
  - `upgrade`=0, `move`=0, `keep`=1, `shcp`=0, `stcp`=0.
- **First frame after `rst` deasserts:** cycle 0 is IDLE; cycle 1 is LOAD with `upgrade`=1. `dp` and `tw` are computed from digit 6.
- **Frame length** (LOAD to next LOAD) = 1 + 28·DIV + DIV + HOLD cycles; 63 for the defaults.
- **Reset mid-operation:** `rst` in any state aborts the frame within the same edge: all outputs return to reset values and there is no partial `stcp`.
- **Simultaneous events:** a blink-counter wrap in the same cycle as a LOAD entry affects `tw` only from the next frame's LOAD entry. An `en` change during SHIFT is ignored.
- **Overlap:** `upgrade` and `move` are never high in the same cycle, and `stcp` and `shcp` are never high together.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles → all outputs at reset values, `keep`=1, `sel`=100000.
- **Single frame** (DIV=2, HOLD=4), `rst` released at cycle 0:
  - `upgrade` only at cycle 1;
  - `move` at cycles 5, 9, …, 57 (14 pulses), with `shcp` high on cycles 4–5, 8–9, …, 56–57;
  - `stcp` on cycles 58–59; next `upgrade` at cycle 64 with `sel`=010000;
  - a model 14-bit sampler on `shcp` rising edges captures {`sel_sd`, ~`dp`, segments}.
- **Scan wrap:** run 7 frames → `sel` sequence 100000, 010000, 001000, 000100, 000010, 000001, 100000.
- **Blink:** set TW_PERIOD=100, `blink_en`=000100 → `tw`=1 only in digit-3 frames whose LOAD falls in a `phase`=1 window; `tw`=0 for every other digit.
- **Enable:** set `en`=0 during digit-4 SHIFT → that frame completes, the controller then stays in HOLD with `keep`=1 and `sel`=001000. Setting `en`=1 → LOAD on the next cycle with `sel`=000100.
- **Abort:** assert `rst` at cycle 30 (mid-SHIFT) → reset values on the next edge, no `stcp` pulse. The first LOAD after release is 1 cycle after IDLE, with `sel`=100000.
